// File: rtl/maxpool_stream.sv
// Streaming non-overlapping max-pool over a raster-order sample stream.
// Keeps one running maximum per output column; trailing partial windows are dropped.
module maxpool_stream #(
  parameter int DW     = 16,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int POOL   = 3,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_st,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          out_valid,
  output logic          out_st,
  output logic          frame_done,
  output logic          busy
);

  localparam int OW = IMG_W / POOL;
  localparam int OH = IMG_H / POOL;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(POOL + 1);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LIM       = CW'(OW * POOL);
  localparam logic [CW-1:0] OC_LAST       = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_LIM       = RW'(OH * POOL);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(POOL - 1);
  localparam logic [RW-1:0] ROW_LAST_OUT  = RW'(OH * POOL - 1);
  localparam logic [PW-1:0] WIN_LAST      = PW'(POOL - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_r;
  logic [CW-1:0] col_r, oc_r;
  logic [RW-1:0] row_r;
  logic [PW-1:0] wc_r, wr_r;
  logic [DW-1:0] acc_r [OW];

  logic          take_s, restart_s, pooled_s, first_s, complete_s, last_s;
  logic [CW-1:0] col_s, oc_s;
  logic [RW-1:0] row_s;
  logic [PW-1:0] wc_s, wr_s;
  logic [DW-1:0] acc_cur_s, max_s, acc_nxt_s;

  function automatic logic greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Effective position of the current sample (a start marker forces (0,0)) and window decode.
  always_comb begin
    take_s    = in_valid && (in_st || (state_r == RUN));
    restart_s = in_valid && in_st;
    col_s     = restart_s ? {CW{1'b0}} : col_r;
    oc_s      = restart_s ? {CW{1'b0}} : oc_r;
    row_s     = restart_s ? {RW{1'b0}} : row_r;
    wc_s      = restart_s ? {PW{1'b0}} : wc_r;
    wr_s      = restart_s ? {PW{1'b0}} : wr_r;
    acc_cur_s = {DW{1'b0}};
    for (int i = 0; i < OW; i++) begin
      if (oc_s == CW'(i)) begin
        acc_cur_s = acc_r[i];
      end else begin
        acc_cur_s = acc_cur_s;
      end
    end
    pooled_s   = (col_s < COL_LIM) && (row_s < ROW_LIM);
    first_s    = (wr_s == {PW{1'b0}}) && (wc_s == {PW{1'b0}});
    max_s      = greater(din, acc_cur_s) ? din : acc_cur_s;
    acc_nxt_s  = first_s ? din : max_s;
    complete_s = pooled_s && (wr_s == WIN_LAST) && (wc_s == WIN_LAST);
    last_s     = (row_s == ROW_LAST) && (col_s == COL_LAST);
  end

  // Frame FSM, position counters, per-column accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      col_r      <= {CW{1'b0}};
      oc_r       <= {CW{1'b0}};
      row_r      <= {RW{1'b0}};
      wc_r       <= {PW{1'b0}};
      wr_r       <= {PW{1'b0}};
      dout       <= {DW{1'b0}};
      out_valid  <= 1'b0;
      out_st     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < OW; i++) begin
        acc_r[i] <= {DW{1'b0}};
      end
    end else begin
      out_valid  <= 1'b0;
      out_st     <= 1'b0;
      frame_done <= 1'b0;
      if (take_s) begin
        for (int i = 0; i < OW; i++) begin
          if (pooled_s && (oc_s == CW'(i))) begin
            acc_r[i] <= acc_nxt_s;
          end
        end
        if (complete_s) begin
          dout       <= max_s;
          out_valid  <= 1'b1;
          out_st     <= (row_s == ROW_FIRST_OUT) && (oc_s == {CW{1'b0}});
          frame_done <= (row_s == ROW_LAST_OUT) && (oc_s == OC_LAST);
        end
        if (last_s) begin
          state_r <= IDLE;
          busy    <= 1'b0;
          col_r   <= {CW{1'b0}};
          oc_r    <= {CW{1'b0}};
          row_r   <= {RW{1'b0}};
          wc_r    <= {PW{1'b0}};
          wr_r    <= {PW{1'b0}};
        end else begin
          state_r <= RUN;
          busy    <= 1'b1;
          if (col_s == COL_LAST) begin
            col_r <= {CW{1'b0}};
            oc_r  <= {CW{1'b0}};
            wc_r  <= {PW{1'b0}};
            row_r <= row_s + RW'(1);
            wr_r  <= (wr_s == WIN_LAST) ? {PW{1'b0}} : (wr_s + PW'(1));
          end else begin
            col_r <= col_s + CW'(1);
            oc_r  <= (wc_s == WIN_LAST) ? (oc_s + CW'(1)) : oc_s;
            wc_r  <= (wc_s == WIN_LAST) ? {PW{1'b0}} : (wc_s + PW'(1));
            row_r <= row_s;
            wr_r  <= wr_s;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: three parameter sets share one stimulus stream and are
// checked every cycle against a frame-buffer model, plus literal output lists.
module tb_maxpool_stream;

  localparam int N = 3;
  localparam int P = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_st = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din = 16'd0;

  logic [15:0] dout_w [N];
  logic        ov_w [N];
  logic        ost_w [N];
  logic        fd_w [N];
  logic        busy_w [N];

  int W_C [N] = '{6, 7, 6};
  int H_C [N] = '{6, 7, 6};
  bit SG_C [N] = '{1'b0, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  // model state
  bit          run_m [N];
  int          r_m [N];
  int          c_m [N];
  logic [15:0] pix [N][7][7];
  logic [15:0] exp_d [N];
  logic        exp_v [N];
  logic        exp_st [N];
  logic        exp_fd [N];
  logic        exp_busy [N];

  logic [15:0] capq [N][$];
  logic [15:0] eq [$];

  always #5 clk = ~clk;

  maxpool_stream #(.DW(16), .IMG_W(6), .IMG_H(6), .POOL(3), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_st(in_st), .in_valid(in_valid), .din(din),
    .dout(dout_w[0]), .out_valid(ov_w[0]), .out_st(ost_w[0]),
    .frame_done(fd_w[0]), .busy(busy_w[0]));

  maxpool_stream #(.DW(16), .IMG_W(7), .IMG_H(7), .POOL(3), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .in_st(in_st), .in_valid(in_valid), .din(din),
    .dout(dout_w[1]), .out_valid(ov_w[1]), .out_st(ost_w[1]),
    .frame_done(fd_w[1]), .busy(busy_w[1]));

  maxpool_stream #(.DW(16), .IMG_W(6), .IMG_H(6), .POOL(3), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .in_st(in_st), .in_valid(in_valid), .din(din),
    .dout(dout_w[2]), .out_valid(ov_w[2]), .out_st(ost_w[2]),
    .frame_done(fd_w[2]), .busy(busy_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit gt(input bit sg, input logic [15:0] a, input logic [15:0] b);
    if (sg) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Stores the frame as it arrives; a finished window's max is taken over the stored pixels.
  task automatic model_step(input int k);
    int pw, ph;
    logic [15:0] m;
    exp_v[k]  = 1'b0;
    exp_st[k] = 1'b0;
    exp_fd[k] = 1'b0;
    if (rst) begin
      run_m[k]    = 1'b0;
      r_m[k]      = 0;
      c_m[k]      = 0;
      exp_d[k]    = 16'd0;
      exp_busy[k] = 1'b0;
      return;
    end
    pw = (W_C[k] / P) * P;
    ph = (H_C[k] / P) * P;
    if (in_valid && (in_st || run_m[k])) begin
      if (in_st) begin
        r_m[k] = 0;
        c_m[k] = 0;
      end
      pix[k][r_m[k]][c_m[k]] = din;
      if ((r_m[k] % P == P - 1) && (c_m[k] % P == P - 1) && (r_m[k] < ph) && (c_m[k] < pw)) begin
        m = pix[k][r_m[k]][c_m[k]];
        for (int rr = r_m[k] - P + 1; rr <= r_m[k]; rr++)
          for (int cc = c_m[k] - P + 1; cc <= c_m[k]; cc++)
            if (gt(SG_C[k], pix[k][rr][cc], m)) m = pix[k][rr][cc];
        exp_d[k]  = m;
        exp_v[k]  = 1'b1;
        exp_st[k] = (r_m[k] == P - 1) && (c_m[k] == P - 1);
        exp_fd[k] = (r_m[k] == ph - 1) && (c_m[k] == pw - 1);
      end
      if ((r_m[k] == H_C[k] - 1) && (c_m[k] == W_C[k] - 1)) begin
        run_m[k] = 1'b0;
        r_m[k]   = 0;
        c_m[k]   = 0;
      end else begin
        run_m[k] = 1'b1;
        c_m[k]++;
        if (c_m[k] == W_C[k]) begin
          c_m[k] = 0;
          r_m[k]++;
        end
      end
    end
    exp_busy[k] = run_m[k];
  endtask

  // Per-cycle comparison against the model; inputs are still those of the last rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      model_step(k);
      chk($sformatf("dut%0d out_valid", k), 32'(ov_w[k]), 32'(exp_v[k]));
      chk($sformatf("dut%0d dout", k), 32'(dout_w[k]), 32'(exp_d[k]));
      chk($sformatf("dut%0d out_st", k), 32'(ost_w[k]), 32'(exp_st[k]));
      chk($sformatf("dut%0d frame_done", k), 32'(fd_w[k]), 32'(exp_fd[k]));
      chk($sformatf("dut%0d busy", k), 32'(busy_w[k]), 32'(exp_busy[k]));
      if (ov_w[k] === 1'b1) capq[k].push_back(dout_w[k]);
    end
  end

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    @(negedge clk);
    #1;
    in_valid = v;
    in_st    = s;
    din      = d;
  endtask

  task automatic clearq();
    for (int k = 0; k < N; k++) capq[k].delete();
  endtask

  task automatic chk_q(input string nm, input int k);
    chk({nm, " count"}, 32'(capq[k].size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (i < capq[k].size()) chk($sformatf("%s[%0d]", nm, i), 32'(capq[k][i]), 32'(eq[i]));
      else chk($sformatf("%s[%0d]", nm, i), 32'hDEAD_BEEF, 32'(eq[i]));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset dout", 32'(dout_w[0]), 32'd0);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset out_valid", 32'(ov_w[0]), 32'd0);
    #1 rst = 1'b0;

    // contiguous 6x6 frame
    clearq();
    for (int i = 0; i < 36; i++) drive(1'b1, i == 0, 16'(i));
    drive(1'b0, 1'b0, 16'd0);
    chk("6x6 busy after last", 32'(busy_w[0]), 32'd0);
    drive(1'b0, 1'b0, 16'd0);
    eq = {16'd14, 16'd17, 16'd32, 16'd35};
    chk_q("6x6 outputs", 0);

    // 7x7 frame with dropped trailing row/column
    clearq();
    for (int i = 0; i < 49; i++) begin
      drive(1'b1, i == 0, 16'(i));
      if (i == 47) chk("7x7 busy past frame_done", 32'(busy_w[1]), 32'd1);
    end
    drive(1'b0, 1'b0, 16'd0);
    chk("7x7 busy after last", 32'(busy_w[1]), 32'd0);
    drive(1'b0, 1'b0, 16'd0);
    eq = {16'd16, 16'd19, 16'd37, 16'd40};
    chk_q("7x7 outputs", 1);

    // descending all-negative frame: same result either way
    clearq();
    for (int i = 0; i < 36; i++) drive(1'b1, i == 0, 16'(16'hFFFF - 16'(i)));
    repeat (2) drive(1'b0, 1'b0, 16'd0);
    eq = {16'hFFFF, 16'hFFFC, 16'hFFED, 16'hFFEA};
    chk_q("neg unsigned", 0);
    chk_q("neg signed", 2);

    // mixed sign: odd samples have bit 15 set
    clearq();
    for (int i = 0; i < 36; i++) drive(1'b1, i == 0, (i % 2 == 0) ? 16'(i) : (16'h8000 | 16'(i)));
    repeat (2) drive(1'b0, 1'b0, 16'd0);
    eq = {16'h800D, 16'h8011, 16'h801F, 16'h8023};
    chk_q("mix unsigned", 0);
    eq = {16'h000E, 16'h0010, 16'h0020, 16'h0022};
    chk_q("mix signed", 2);

    // gapped input
    clearq();
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, i == 0, 16'(i));
      drive(1'b0, 1'b0, 16'hABCD);
    end
    drive(1'b0, 1'b0, 16'd0);
    eq = {16'd14, 16'd17, 16'd32, 16'd35};
    chk_q("gapped", 0);

    // restart right after the window ending at 17 completes
    clearq();
    for (int i = 0; i < 18; i++) drive(1'b1, i == 0, 16'(i));
    for (int i = 0; i < 36; i++) drive(1'b1, i == 0, 16'(100 + i));
    repeat (2) drive(1'b0, 1'b0, 16'd0);
    eq = {16'd14, 16'd17, 16'd114, 16'd117, 16'd132, 16'd135};
    chk_q("restart", 0);

    // asynchronous reset mid-frame
    clearq();
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 16'(i));
    drive(1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    #1;
    chk("async rst dout", 32'(dout_w[0]), 32'd0);
    chk("async rst busy", 32'(busy_w[0]), 32'd0);
    chk("async rst out_valid", 32'(ov_w[0]), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    clearq();
    for (int i = 0; i < 36; i++) drive(1'b1, i == 0, 16'(i));
    repeat (2) drive(1'b0, 1'b0, 16'd0);
    eq = {16'd14, 16'd17, 16'd32, 16'd35};
    chk_q("after reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
